bcd_display_driver: RTL and testbench

Parametrised multi-channel binary-to-seven-segment display driver. Accepts CHANNELS binary values in one handshake and converts each sequentially with a shift-add-3 (double-dabble) engine. Commits all channels' active-low segment patterns atomically, with per-channel overflow indication and optional leading-zero blanking. Sits between the processing core's result outputs (x/y coordinates) and the board's seven-segment pins, replacing the combinational BCD/segment path and its output register.

---
 rtl/display_pkg.sv | 35 +++
 rtl/seg7_encode.sv | 36 +++
 rtl/bcd_display_driver.sv | 182 ++++++++++++++++++
 tb/tb_bcd_display_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display driver.
// - SEG_DIGIT / SEG_BLANK / SEG_DASH: active-low patterns, bit order {g,f,e,d,c,b,a}
// - state_t: conversion FSM states
// - cnt_width(): width of the per-channel shift counter
package display_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StStore
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Index n holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Counter must hold 0..width-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// BCD nibble to active-low seven-segment pattern.
// - bcd   : decimal digit 0..9 (other codes show blank)
// - blank : force blank pattern
// - dash  : force dash pattern (takes priority over blank)
// - seg   : {g,f,e,d,c,b,a}, active-low
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Multi-channel binary to seven-segment driver built around one shared
// double-dabble engine that converts the channels one after another.
// - clock, reset      : rising-edge clock, synchronous active-high reset
// - in_valid/in_ready : request handshake; value_in sampled on acceptance
// - value_in          : channel c at [c*WIDTH +: WIDTH]
// - clear             : blank seg_out at the next edge
// - busy, done        : conversion in progress / one-cycle commit pulse
// - overflow          : per-channel value >= 10^DIGITS
// - seg_out           : channel c digit d at [(c*DIGITS+d)*7 +: 7], active-low
module bcd_display_driver
    import display_pkg::*;
#(
    parameter int unsigned WIDTH         = 10,
    parameter int unsigned DIGITS        = 3,
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    value_in,
    input  logic                         clear,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS-1:0]          overflow,
    output logic [CHANNELS*DIGITS*7-1:0] seg_out
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned BcdW = DIGITS * 4;
    localparam int unsigned BufW = CHANNELS * BcdW;
    localparam int unsigned NDig = CHANNELS * DIGITS;

    state_t                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [ChW-1:0]              ch_q, ch_d;
    logic [CHANNELS*WIDTH-1:0]   shadow_q, shadow_d;
    logic [BcdW-1:0]             bcd_q, bcd_d;
    logic                        ovf_q, ovf_d;
    logic [BufW-1:0]             buf_q, buf_d;
    logic [CHANNELS-1:0]         buf_ovf_q, buf_ovf_d;
    logic [CHANNELS*DIGITS*7-1:0] seg_q, enc_seg;
    logic [CHANNELS-1:0]         ovf_out_q;
    logic                        done_q;
    logic                        commit;
    logic [BcdW-1:0]             adj;
    logic [NDig-1:0]             blank_vec, dash_vec;
    logic                        hi_zero;

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bcd_q[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
            end
        end
    end

    // The current channel always sits in the low WIDTH bits of the shadow
    // register, and the result buffer fills from the top, so no variable
    // indexing by channel is needed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        shadow_d  = shadow_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        buf_d     = buf_q;
        buf_ovf_d = buf_ovf_q;
        commit    = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shadow_d = value_in;
                    cnt_d    = '0;
                    ch_d     = '0;
                    bcd_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                bcd_d                = {adj[BcdW-2:0], shadow_q[WIDTH-1]};
                ovf_d                = ovf_q | adj[BcdW-1];
                shadow_d[WIDTH-1:0]  = shadow_q[WIDTH-1:0] << 1;
                cnt_d                = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StStore;
                end
            end
            StStore: begin
                buf_d                     = buf_q >> BcdW;
                buf_d[BufW-1 -: BcdW]     = bcd_q;
                buf_ovf_d                 = buf_ovf_q >> 1;
                buf_ovf_d[CHANNELS-1]     = ovf_q;
                shadow_d                  = shadow_q >> WIDTH;
                bcd_d                     = '0;
                ovf_d                     = 1'b0;
                cnt_d                     = '0;
                if (ch_q == ChW'(CHANNELS - 1)) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = StShift;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Display controls derived from the buffer as it will be after this edge,
    // so the commit sees the channel being stored in the same cycle.
    always_comb begin
        blank_vec = '0;
        dash_vec  = '0;
        hi_zero   = 1'b1;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            hi_zero = 1'b1;
            for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
                hi_zero = hi_zero & (buf_d[(c*int'(DIGITS)+d)*4 +: 4] == 4'd0);
                blank_vec[c*int'(DIGITS)+d] = (BLANK_LEADING != 0) && (d != 0) && hi_zero;
                dash_vec[c*int'(DIGITS)+d]  = buf_ovf_d[c];
            end
        end
    end

    for (genvar i = 0; i < int'(NDig); i++) begin : g_enc
        seg7_encode u_enc (
            .bcd   (buf_d[i*4 +: 4]),
            .blank (blank_vec[i]),
            .dash  (dash_vec[i]),
            .seg   (enc_seg[i*7 +: 7])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ch_q      <= '0;
            shadow_q  <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            buf_q     <= '0;
            buf_ovf_q <= '0;
            seg_q     <= '1;
            ovf_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            shadow_q  <= shadow_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            buf_q     <= buf_d;
            buf_ovf_q <= buf_ovf_d;
            done_q    <= commit;
            if (commit) begin
                ovf_out_q <= buf_ovf_d;
            end
            // clear wins over a coincident commit
            if (clear) begin
                seg_q <= '1;
            end else if (commit) begin
                seg_q <= enc_seg;
            end
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign overflow = ovf_out_q;
    assign seg_out  = seg_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
module tb_bcd_display_driver;

    localparam int LAT = 22;  // accept edge to commit edge, default parameters

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [19:0] value_in = '0;
    logic        clear = 1'b0;

    logic        rdy_a, busy_a, done_a;
    logic [1:0]  ovf_a;
    logic [41:0] seg_a;
    logic        rdy_b, busy_b, done_b;
    logic [1:0]  ovf_b;
    logic [41:0] seg_b;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        logic [41:0] seg_a;
        logic [41:0] seg_b;
        logic [1:0]  ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    bcd_display_driver #(.WIDTH(10), .DIGITS(3), .CHANNELS(2), .BLANK_LEADING(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (rdy_a),
        .value_in (value_in),
        .clear    (clear),
        .busy     (busy_a),
        .done     (done_a),
        .overflow (ovf_a),
        .seg_out  (seg_a)
    );

    bcd_display_driver #(.WIDTH(10), .DIGITS(3), .CHANNELS(2), .BLANK_LEADING(0)) dut_nb (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (rdy_b),
        .value_in (value_in),
        .clear    (clear),
        .busy     (busy_b),
        .done     (done_b),
        .overflow (ovf_b),
        .seg_out  (seg_b)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic logic [6:0] digit_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected 3-digit channel pattern from hand-written BCD digits.
    function automatic logic [20:0] chan_seg(input logic [11:0] bcd, input logic ovf, input bit bl);
        logic [20:0] r;
        logic [3:0]  n;
        bit          lead;
        r    = '1;
        lead = 1'b1;
        for (int d = 2; d >= 0; d--) begin
            n = bcd[d*4 +: 4];
            if (ovf) r[d*7 +: 7] = 7'b0111111;
            else if (bl && lead && n == 4'd0 && d != 0) r[d*7 +: 7] = 7'b1111111;
            else begin
                r[d*7 +: 7] = digit_seg(n);
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!rdy_a && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!rdy_a) chk("ready_timeout", rdy_a, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    // Issue one request; expected response goes to the scoreboard.
    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [11:0] xb,
                        input logic [11:0] yb, input logic [1:0] ov, input bit clr_commit);
        exp_t e;
        wait_ready();
        value_in = {y, x};
        in_valid = 1'b1;
        e.seg_a  = clr_commit ? '1 : {chan_seg(yb, ov[1], 1), chan_seg(xb, ov[0], 1)};
        e.seg_b  = clr_commit ? '1 : {chan_seg(yb, ov[1], 0), chan_seg(xb, ov[0], 0)};
        e.ovf    = ov;
        e.acc    = cyc + 1;
        sb.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
        if (clr_commit) begin
            repeat (LAT - 1) @(negedge clock);
            clear = 1'b1;
            @(negedge clock);
            clear = 1'b0;
        end
    endtask

    // Monitor: compare on every done pulse.
    always @(negedge clock) begin
        exp_t e;
        if (done_a || done_b) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {done_b, done_a}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("done_nb", done_b, 1);
                chk("done_a", done_a, 1);
                chk("seg_bl1", seg_a, e.seg_a);
                chk("seg_bl0", seg_b, e.seg_b);
                chk("overflow", ovf_a, e.ovf);
                chk("overflow_nb", ovf_b, e.ovf);
                chk("ready_in_done", rdy_a, 1);
                chk("latency", cyc - e.acc, LAT);
            end
        end
    end

    initial begin
        int acc;
        repeat (2) @(negedge clock);
        chk("rst_seg", seg_a, {42{1'b1}});
        chk("rst_ovf", ovf_a, 2'b00);
        chk("rst_ready", rdy_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 0);
        reset = 1'b0;

        send(10'd639,  10'd479, 12'h639, 12'h479, 2'b00, 0);
        send(10'd1023, 10'd999, 12'h000, 12'h999, 2'b01, 0);
        send(10'd7,    10'd0,   12'h007, 12'h000, 2'b00, 0);
        send(10'd999,  10'd1000, 12'h999, 12'h000, 2'b10, 0);
        drain();

        // clear while idle: blank segments, overflow retained
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("idle_clear_seg", seg_a, {42{1'b1}});
        chk("idle_clear_seg_nb", seg_b, {42{1'b1}});
        chk("idle_clear_ovf", ovf_a, 2'b10);
        chk("idle_clear_done", done_a, 0);

        send(10'd100, 10'd50, 12'h100, 12'h050, 2'b00, 0);

        // request while busy must be ignored
        send(10'd123, 10'd456, 12'h123, 12'h456, 2'b00, 0);
        repeat (4) @(negedge clock);
        chk("busy_ready", rdy_a, 0);
        chk("busy_flag", busy_a, 1);
        value_in = {10'd777, 10'd888};
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        drain();

        // reset in the middle of a conversion
        wait_ready();
        value_in = {10'd222, 10'd111};
        in_valid = 1'b1;
        acc = cyc + 1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (9) @(negedge clock);
        chk("pre_reset_busy", busy_a, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_seg", seg_a, {42{1'b1}});
        chk("midrst_ovf", ovf_a, 2'b00);
        chk("midrst_ready", rdy_a, 1);
        chk("midrst_done", done_a, 0);
        chk("midrst_cycle", cyc - acc, 10);
        repeat (30) @(negedge clock);

        send(10'd45,  10'd678, 12'h045, 12'h678, 2'b00, 0);
        send(10'd321, 10'd10,  12'h321, 12'h010, 2'b00, 1);
        drain();
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
